// File: rtl/countdown_display.sv
// Binary-to-BCD conversion (sequential double-dabble) of the countdown value,
// driving a multiplexed common-anode 3-digit 7-segment display with leading-zero blanking.
module countdown_display #(
    parameter int WIDTH    = 9,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      current,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  update,
    output logic                  is_zero,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(DIGITS);
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_load;
    logic               w_shift;
    logic               w_done;

    logic [WIDTH-1:0]   r_bin;
    logic [WIDTH-1:0]   r_captured;
    logic [WIDTH-1:0]   r_last_value;
    logic [BCD_W-1:0]   r_scratch;
    logic [BCD_W-1:0]   w_adj;
    logic [CNT_W-1:0]   r_shift_cnt;
    logic               r_first;

    logic [BCD_W-1:0]   r_bcd;
    logic               r_update;
    logic               r_is_zero;

    logic [PRE_W-1:0]   r_prescaler;
    logic [IDX_W-1:0]   r_digit_idx;
    logic [DIGITS-1:0]  r_an;
    logic [6:0]         r_seg;
    logic [3:0]         w_nibble;
    logic               w_blank;
    logic [6:0]         w_seg;
    logic [DIGITS-1:0]  w_an;

    // ---------------- conversion FSM ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal gets a default before the case, otherwise an
    // unassigned path would infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_first || (current != r_last_value)) begin
                    w_load       = 1'b1;
                    w_next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_shift = 1'b1;
                if (r_shift_cnt == CNT_W'(1)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Double-dabble correction: any nibble >= 5 would exceed 9 after doubling.
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_bin        <= '0;
            r_captured   <= '0;
            r_last_value <= '0;
            r_scratch    <= '0;
            r_shift_cnt  <= '0;
            r_first      <= 1'b1;
            r_bcd        <= '0;
            r_update     <= 1'b0;
            r_is_zero    <= 1'b1;
        end else begin
            r_update <= w_done;
            if (w_load) begin
                r_bin       <= current;
                r_captured  <= current;
                r_scratch   <= '0;
                r_shift_cnt <= CNT_W'(WIDTH);
            end
            if (w_shift) begin
                r_scratch   <= {w_adj[BCD_W-2:0], r_bin[WIDTH-1]};
                r_bin       <= {r_bin[WIDTH-2:0], 1'b0};
                r_shift_cnt <= r_shift_cnt - CNT_W'(1);
            end
            if (w_done) begin
                r_bcd        <= r_scratch;
                r_last_value <= r_captured;
                r_is_zero    <= (r_scratch == '0);
                r_first      <= 1'b0;
            end
        end
    end

    // ---------------- display scan ----------------
    always_comb begin
        w_nibble = r_bcd[3:0];
        w_blank  = 1'b0;
        case (r_digit_idx)
            IDX_W'(1): begin
                w_nibble = r_bcd[7:4];
                w_blank  = (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0);
            end
            IDX_W'(2): begin
                w_nibble = r_bcd[11:8];
                w_blank  = (r_bcd[11:8] == 4'd0);
            end
            default: begin
                w_nibble = r_bcd[3:0];
                w_blank  = 1'b0;
            end
        endcase
    end

    // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles show nothing.
    always_comb begin
        w_seg = 7'b1111111;
        if (!w_blank) begin
            case (w_nibble)
                4'd0: w_seg = 7'b1000000;
                4'd1: w_seg = 7'b1111001;
                4'd2: w_seg = 7'b0100100;
                4'd3: w_seg = 7'b0110000;
                4'd4: w_seg = 7'b0011001;
                4'd5: w_seg = 7'b0010010;
                4'd6: w_seg = 7'b0000010;
                4'd7: w_seg = 7'b1111000;
                4'd8: w_seg = 7'b0000000;
                4'd9: w_seg = 7'b0010000;
                default: w_seg = 7'b1111111;
            endcase
        end
    end

    assign w_an = ~(DIGITS'(1) << r_digit_idx);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_prescaler <= '0;
            r_digit_idx <= '0;
            r_an        <= ~DIGITS'(1);
            r_seg       <= 7'b1000000;
        end else begin
            r_an  <= w_an;
            r_seg <= w_seg;
            if (r_prescaler == PRE_W'(SCAN_DIV - 1)) begin
                r_prescaler <= '0;
                r_digit_idx <= (r_digit_idx == IDX_W'(DIGITS - 1)) ? '0 : r_digit_idx + IDX_W'(1);
            end else begin
                r_prescaler <= r_prescaler + PRE_W'(1);
            end
        end
    end

    assign bcd     = r_bcd;
    assign update  = r_update;
    assign is_zero = r_is_zero;
    assign an      = r_an;
    assign seg     = r_seg;

endmodule

// File: tb/tb_countdown_display.sv
// Scoreboard-driven bench for countdown_display: conversions, latency, scan order,
// leading-zero blanking, skipped inputs and mid-conversion reset.
module tb_countdown_display;

    localparam int WIDTH    = 9;
    localparam int DIGITS   = 3;
    localparam int SCAN_DIV = 4;
    localparam int LAT      = WIDTH + 2;  // input set before capture edge -> update visible

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [WIDTH-1:0]  current = '0;
    logic [11:0]       bcd;
    logic              update;
    logic              is_zero;
    logic [2:0]        an;
    logic [6:0]        seg;

    int checks  = 0;
    int errors  = 0;
    int upd_cnt = 0;
    logic [11:0] exp_q[$];

    countdown_display #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clock   (clock),
        .reset   (reset),
        .current (current),
        .bcd     (bcd),
        .update  (update),
        .is_zero (is_zero),
        .an      (an),
        .seg     (seg)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (update === 1'b1) upd_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [2:0] a, input logic [11:0] b);
        case (a)
            3'b110: return dec(b[3:0]);
            3'b101: return (b[11:8] == 0 && b[7:4] == 0) ? 7'b1111111 : dec(b[7:4]);
            3'b011: return (b[11:8] == 0) ? 7'b1111111 : dec(b[11:8]);
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    task automatic wait_update(input int limit, output int cycles, output bit found);
        found  = 1'b0;
        cycles = 0;
        while (!found && cycles < limit) begin
            tick();
            cycles++;
            if (update === 1'b1) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        int cyc;
        bit found;
        logic [11:0] exp;
        exp = 12'hfff;
        reset = 1'b0;
        current = '0;
        tick();
        tick();
        checks++; if (bcd !== 12'h000) begin errors++; $display("FAIL reset_bcd got %h want 000", bcd); end
        checks++; if (update !== 1'b0) begin errors++; $display("FAIL reset_update got %b want 0", update); end
        checks++; if (is_zero !== 1'b1) begin errors++; $display("FAIL reset_is_zero got %b want 1", is_zero); end
        checks++; if (an !== 3'b110) begin errors++; $display("FAIL reset_an got %b want 110", an); end
        checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL reset_seg got %b want 1000000", seg); end
        reset = 1'b1;
        exp_q.push_back(to_bcd(0));
        wait_update(3 * LAT, cyc, found);
        checks++; if (!found || cyc != LAT) begin errors++; $display("FAIL first_latency got %0d found %b want %0d", cyc, found, LAT); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL first_queue empty on update"); end
        else begin
            exp = exp_q.pop_front();
            if (bcd !== exp) begin errors++; $display("FAIL first_bcd got %h want %h", bcd, exp); end
        end
        checks++; if (is_zero !== (exp == 12'h000)) begin errors++; $display("FAIL first_is_zero got %b want %b", is_zero, exp == 12'h000); end
        for (int i = 0; i < 3 * SCAN_DIV + 2; i++) begin
            tick();
            checks++;
            if (seg !== exp_seg(an, exp)) begin errors++; $display("FAIL zero_seg an %b got %b want %b", an, seg, exp_seg(an, exp)); end
        end
    endtask

    task automatic test_scan();
        int cyc, run;
        bit found, seen_change;
        logic [11:0] exp;
        logic [2:0] prev_an;
        exp = 12'hfff;
        current = 9'd511;
        exp_q.push_back(to_bcd(511));
        wait_update(3 * LAT, cyc, found);
        checks++; if (!found || cyc != LAT) begin errors++; $display("FAIL scan_latency got %0d found %b want %0d", cyc, found, LAT); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL scan_queue empty on update"); end
        else begin
            exp = exp_q.pop_front();
            if (bcd !== exp) begin errors++; $display("FAIL scan_bcd got %h want %h", bcd, exp); end
        end
        checks++; if (is_zero !== 1'b0) begin errors++; $display("FAIL scan_is_zero got %b want 0", is_zero); end
        tick();
        prev_an = an;
        run = 1;
        seen_change = 1'b0;
        for (int i = 0; i < 8 * SCAN_DIV; i++) begin
            tick();
            checks++;
            if (seg !== exp_seg(an, exp)) begin errors++; $display("FAIL scan_seg an %b got %b want %b", an, seg, exp_seg(an, exp)); end
            if (an === prev_an) begin
                run++;
            end else begin
                checks++;
                if (an !== {prev_an[1:0], prev_an[2]}) begin errors++; $display("FAIL scan_order got %b want %b", an, {prev_an[1:0], prev_an[2]}); end
                if (seen_change) begin
                    checks++;
                    if (run != SCAN_DIV) begin errors++; $display("FAIL scan_hold got %0d want %0d", run, SCAN_DIV); end
                end
                seen_change = 1'b1;
                run = 1;
                prev_an = an;
            end
        end
    endtask

    task automatic test_steps();
        int vals[3] = '{100, 99, 9};
        int cyc, base;
        bit found;
        logic [11:0] exp;
        foreach (vals[k]) begin
            exp = 12'hfff;
            base = upd_cnt;
            current = WIDTH'(vals[k]);
            exp_q.push_back(to_bcd(vals[k]));
            wait_update(3 * LAT, cyc, found);
            checks++; if (!found || cyc != LAT) begin errors++; $display("FAIL step_latency val %0d got %0d want %0d", vals[k], cyc, LAT); end
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL step_queue empty on update"); end
            else begin
                exp = exp_q.pop_front();
                if (bcd !== exp) begin errors++; $display("FAIL step_bcd got %h want %h", bcd, exp); end
            end
            for (int i = 0; i < 3 * SCAN_DIV + 2; i++) begin
                tick();
                checks++;
                if (seg !== exp_seg(an, exp)) begin errors++; $display("FAIL step_seg val %0d an %b got %b want %b", vals[k], an, seg, exp_seg(an, exp)); end
            end
            checks++; if (upd_cnt - base != 1) begin errors++; $display("FAIL step_pulses val %0d got %0d want 1", vals[k], upd_cnt - base); end
        end
    endtask

    task automatic test_back_to_back();
        int cyc, base;
        bit found;
        logic [11:0] exp;
        base = upd_cnt;
        current = 9'd123;
        exp_q.push_back(to_bcd(123));
        tick();
        for (int v = 124; v <= 130; v++) begin
            current = WIDTH'(v);
            tick();
        end
        exp_q.push_back(to_bcd(130));
        for (int n = 0; n < 2; n++) begin
            exp = 12'hfff;
            wait_update(3 * LAT, cyc, found);
            checks++; if (!found) begin errors++; $display("FAIL b2b_timeout conversion %0d got none want update", n); end
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_queue empty on update"); end
            else begin
                exp = exp_q.pop_front();
                if (bcd !== exp) begin errors++; $display("FAIL b2b_bcd conversion %0d got %h want %h", n, bcd, exp); end
            end
        end
        repeat (2 * LAT) tick();
        checks++; if (upd_cnt - base != 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", upd_cnt - base); end
    endtask

    task automatic test_constant();
        int base;
        base = upd_cnt;
        repeat (100) tick();
        checks++; if (upd_cnt - base != 0) begin errors++; $display("FAIL const_pulses got %0d want 0", upd_cnt - base); end
        checks++; if (bcd !== to_bcd(130)) begin errors++; $display("FAIL const_bcd got %h want %h", bcd, to_bcd(130)); end
    endtask

    task automatic test_reset_mid();
        int cyc, base;
        bit found;
        logic [11:0] exp;
        exp = 12'hfff;
        base = upd_cnt;
        current = 9'd300;
        tick();               // capture edge
        repeat (4) tick();    // SHIFT edges 1..4
        reset = 1'b0;
        tick();               // 5th SHIFT edge sees reset
        checks++; if (bcd !== 12'h000) begin errors++; $display("FAIL mid_bcd got %h want 000", bcd); end
        checks++; if (is_zero !== 1'b1) begin errors++; $display("FAIL mid_is_zero got %b want 1", is_zero); end
        checks++; if (update !== 1'b0) begin errors++; $display("FAIL mid_update got %b want 0", update); end
        checks++; if (an !== 3'b110) begin errors++; $display("FAIL mid_an got %b want 110", an); end
        checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL mid_seg got %b want 1000000", seg); end
        checks++; if (upd_cnt - base != 0) begin errors++; $display("FAIL mid_aborted_pulse got %0d want 0", upd_cnt - base); end
        reset = 1'b1;
        exp_q.push_back(to_bcd(300));
        wait_update(LAT, cyc, found);
        checks++; if (!found) begin errors++; $display("FAIL mid_reconvert got no update within %0d want update", LAT); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL mid_queue empty on update"); end
        else begin
            exp = exp_q.pop_front();
            if (bcd !== exp) begin errors++; $display("FAIL mid_result got %h want %h", bcd, exp); end
        end
        checks++; if (is_zero !== 1'b0) begin errors++; $display("FAIL mid_result_zero got %b want 0", is_zero); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_steps();
        test_back_to_back();
        test_constant();
        test_reset_mid();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL leftover_expected got %0d want 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_display.md
Name: countdown_display

Overview:
- Downstream consumer of the 9-bit countdown value produced by the countdown counter stage.
- Converts the binary count (0..511) to three BCD digits with a sequential double-dabble engine.
- Drives a time-multiplexed, common-anode 3-digit 7-segment display, with leading-zero blanking and a zero-reached flag.

Parameters:
- WIDTH, 9, width of the binary input value; the conversion takes WIDTH shift cycles.
- DIGITS, 3, number of BCD digits and display anodes; fixed to 3 for WIDTH=9.
- SCAN_DIV, 1000, clock cycles each digit stays enabled before the scan advances; must be >= 2.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  one clock; reset is synchronous and active-low (reset=0 sampled on a rising edge clears all state).
- current  input  WIDTH  binary count from the countdown counter stage.
- bcd  output  4*DIGITS  last completed conversion: [11:8] hundreds, [7:4] tens, [3:0] ones.
- update  output  1  one-cycle pulse on the edge bcd is written.
- is_zero  output  1  high when bcd == 0; registered together with bcd.
- an  output  DIGITS  active-low one-hot digit enable; bit0 = ones.
- seg  output  7  active-low segments {g,f,e,d,c,b,a}.

Behaviour:
- Reset (reset=0 at an edge): FSM=IDLE, bcd=0, update=0, is_zero=1, last_value=0, first_flag=1, prescaler=0, digit_idx=0, an=3'b110, seg=7'b1000000 ('0').
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if first_flag=1 or current != last_value:
  - capture current into the shift register and the scratch BCD field (cleared to 0);
  - set shift_cnt=WIDTH and go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT (one step per clock):
  - add 3 to every scratch nibble >= 5;
  - shift {scratch, binary} left by 1;
  - decrement shift_cnt; when shift_cnt reaches 1 this cycle, go to DONE.
  - Exactly WIDTH SHIFT cycles are taken.
- DONE:
  - bcd <= scratch; last_value <= captured value; is_zero <= (scratch == 0);
  - update=1 for this one cycle; first_flag <= 0; go to IDLE.
- Latency: capture at edge N, shifts at edges N+1..N+WIDTH, bcd/update valid after edge N+WIDTH+1 (N+10 for WIDTH=9).
- Minimum re-conversion interval: WIDTH+2 cycles.
- Changes on current during SHIFT/DONE are ignored. The value present at the next IDLE edge is converted; intermediate values may be skipped.
- Arithmetic: scratch field is 4*DIGITS bits. Nibble add is mod 16. Inputs up to 2^WIDTH-1 must never overflow the hundreds nibble (511 -> 5,1,1).
- Scan:
  - prescaler counts 0..SCAN_DIV-1 every clock; on the edge it wraps to 0, digit_idx advances 0->1->2->0.
  - an and seg are registered and reload every clock from the current digit_idx and bcd, so they lag a digit_idx or bcd change by one cycle.
  - an = ~(1 << digit_idx).
- Decode: 0..9 use standard patterns, e.g. 0=1000000, 1=1111001, 5=0010010. Nibble values 10..15 produce blank (1111111).
- Leading-zero blanking:
  - hundreds digit is blank when hundreds==0;
  - tens digit is blank when hundreds==0 and tens==0;
  - ones digit is always lit.
- Scan and conversion are independent. Scan continues during conversion and shows the previous bcd until DONE.
- Reset mid-conversion: abort, return to reset state, and reconvert the current input on the first IDLE edge after release.

Test Plan:
- Release reset with current=0 -> first conversion starts on the next edge; update pulses 10 cycles later; bcd=12'h000, is_zero=1; an cycles 110,101,011; seg shows '0' only on ones, blank on tens and hundreds.
- Hold current=511 -> after 10 cycles bcd=12'h511, is_zero=0; with SCAN_DIV=4, seg sequence ones=1111001, tens=1111001, hundreds=0010010, each digit held 4 cycles.
- Step current 100 -> 99 -> 9 with >= 12 cycles between steps -> bcd = 12'h100, 12'h099, 12'h009; tens blank for 9, hundreds blank for 99 and 9; exactly one update pulse per change.
- Change current on every clock during a conversion (123, then 124..130) -> only 123 is reported first, then the value sampled at the next IDLE edge; no update pulse for skipped values.
- Constant current for 100 cycles after a conversion -> no further update pulses and the FSM stays in IDLE.
- Assert reset at the 5th SHIFT cycle of converting 300 -> all outputs return to reset values; after release, bcd=12'h300 within 11 cycles.
